// File: rtl/fetch_stage.sv
// Instruction fetch: presents cpc to the I-cache, latches hit data into IF/ID, drives PC write enable.
// Latency: a hit reaches IF/ID one edge after its ihit cycle; a skid-held hit one edge after stall drops.
// Backpressure: stall freezes IF/ID; a hit during stall is parked in a one-entry skid and fetch pauses.
module fetch_stage #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [WORD_W-1:0] cpc,
    input  logic [WORD_W-1:0] pc_plus,
    input  logic              ihit,
    input  logic [WORD_W-1:0] imemload,
    input  logic              stall,
    input  logic              flush,
    input  logic              halt,
    output logic              imemREN,
    output logic [WORD_W-1:0] imemaddr,
    output logic              pc_wen,
    output logic              ifid_valid,
    output logic [WORD_W-1:0] ifid_instr,
    output logic [WORD_W-1:0] ifid_pc,
    output logic [WORD_W-1:0] ifid_pc_plus,
    output logic [CNT_W-1:0]  fetch_cnt
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HELD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               valid_q, valid_d;
    logic [WORD_W-1:0]  instr_q, instr_d;
    logic [WORD_W-1:0]  pc_q, pc_d;
    logic [WORD_W-1:0]  pcp_q, pcp_d;
    logic [WORD_W-1:0]  skid_instr_q, skid_instr_d;
    logic [WORD_W-1:0]  skid_pc_q, skid_pc_d;
    logic [WORD_W-1:0]  skid_pcp_q, skid_pcp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               pc_wen_c;

    // State, IF/ID latch, skid entry and hit counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= FETCH;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc_q         <= '0;
            pcp_q        <= '0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
            skid_pcp_q   <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            instr_q      <= instr_d;
            pc_q         <= pc_d;
            pcp_q        <= pcp_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pcp_q   <= skid_pcp_d;
            cnt_q        <= cnt_d;
        end
    end

    // Next-state and PC write enable; priority is halt, then flush, then stall, then normal flow.
    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        instr_d      = instr_q;
        pc_d         = pc_q;
        pcp_d        = pcp_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pcp_d   = skid_pcp_q;
        cnt_d        = cnt_q;
        pc_wen_c     = 1'b0;

        if (state_q != HALTED) begin
            if (halt) begin
                state_d      = HALTED;
                valid_d      = 1'b0;
                instr_d      = '0;
                skid_instr_d = '0;
                skid_pc_d    = '0;
                skid_pcp_d   = '0;
            end else if (flush) begin
                // Let the PC load its redirect target; whatever is in flight is squashed.
                pc_wen_c     = 1'b1;
                state_d      = FETCH;
                valid_d      = 1'b0;
                instr_d      = '0;
                skid_instr_d = '0;
                skid_pc_d    = '0;
                skid_pcp_d   = '0;
            end else if (stall) begin
                // Park a hit that lands while decode holds, so the PC can advance exactly once for it.
                if (state_q == FETCH && ihit) begin
                    skid_instr_d = imemload;
                    skid_pc_d    = cpc;
                    skid_pcp_d   = pc_plus;
                    pc_wen_c     = 1'b1;
                    cnt_d        = cnt_q + CNT_W'(1);
                    state_d      = HELD;
                end
            end else if (state_q == FETCH) begin
                if (ihit) begin
                    valid_d  = 1'b1;
                    instr_d  = imemload;
                    pc_d     = cpc;
                    pcp_d    = pc_plus;
                    pc_wen_c = 1'b1;
                    cnt_d    = cnt_q + CNT_W'(1);
                end else begin
                    valid_d = 1'b0;
                    instr_d = '0;
                end
            end else begin
                // HELD draining: PC already advanced when the hit was parked.
                valid_d      = 1'b1;
                instr_d      = skid_instr_q;
                pc_d         = skid_pc_q;
                pcp_d        = skid_pcp_q;
                skid_instr_d = '0;
                skid_pc_d    = '0;
                skid_pcp_d   = '0;
                state_d      = FETCH;
            end
        end
    end

    assign imemREN      = (state_q == FETCH);
    assign imemaddr     = cpc;
    assign pc_wen       = pc_wen_c;
    assign ifid_valid   = valid_q;
    assign ifid_instr   = instr_q;
    assign ifid_pc      = pc_q;
    assign ifid_pc_plus = pcp_q;
    assign fetch_cnt    = cnt_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage sitting directly downstream of the program counter block. It presents the current PC to the instruction cache, waits for ihit, and captures the instruction together with its PC and PC+4 into the IF/ID latch. It generates the PC block's write enable, so the PC advances only when an instruction has been accepted or a redirect is taken. A one-entry skid buffer absorbs a hit that lands while decode is stalled.

Parameters:
WORD_W, 32, width of instruction, PC and data words (matches word_t)
CNT_W, 32, width of the fetched-instruction performance counter

Ports:
CLK  input  1  system clock, rising edge
nRST  input  1  asynchronous active-low reset
cpc  input  WORD_W  current PC from the PC block
pc_plus  input  WORD_W  cpc+4 from the PC block
ihit  input  1  instruction cache hit; imemload is valid this cycle
imemload  input  WORD_W  instruction data from the cache
stall  input  1  decode/hazard unit: IF/ID must hold
flush  input  1  branch/jump redirect taken; squash the fetch path
halt  input  1  halt decoded downstream; stop fetching permanently
imemREN  output  1  instruction read enable to the cache
imemaddr  output  WORD_W  instruction fetch address
pc_wen  output  1  write enable to the PC block (the PC block's wen input)
ifid_valid  output  1  IF/ID latch holds a real instruction
ifid_instr  output  WORD_W  latched instruction (0 = nop when invalid)
ifid_pc  output  WORD_W  PC of the latched instruction
ifid_pc_plus  output  WORD_W  PC+4 of the latched instruction
fetch_cnt  output  CNT_W  count of accepted instruction hits

Behaviour:
- Single clock CLK; nRST is asynchronous and active-low. On reset: state=FETCH, ifid_valid=0, ifid_instr=0, ifid_pc=0, ifid_pc_plus=0, skid buffer empty/zero, fetch_cnt=0.
- States: FETCH, HELD, HALTED.
- Combinational outputs: imemaddr=cpc always. imemREN=1 only in FETCH. pc_wen as defined below, always 0 in HELD/HALTED, except for a flush in HELD.
- Per-cycle priority: halt > flush > stall > normal.
- halt (any state): next state HALTED; ifid_valid←0, ifid_instr←0; pc_wen=0; skid cleared. HALTED is sticky until reset, and all later inputs are ignored.
- flush (not halted): pc_wen=1 for this cycle so the PC loads its redirect target; ifid_valid←0, ifid_instr←0; skid cleared; next state FETCH. A coincident ihit is discarded and fetch_cnt does not increment.
- stall in FETCH with ihit: skid←{imemload, cpc, pc_plus}; pc_wen=1; fetch_cnt+1; next state HELD; IF/ID holds.
- stall in FETCH without ihit: pc_wen=0; IF/ID holds.
- stall in HELD: everything holds; pc_wen=0.
- Normal operation in FETCH with ihit: IF/ID←{1, imemload, cpc, pc_plus} at the next edge; pc_wen=1; fetch_cnt+1.
- Normal operation in FETCH without ihit: pc_wen=0; bubble inserted (ifid_valid←0, ifid_instr←0, ifid_pc and ifid_pc_plus hold).
- Normal operation in HELD: IF/ID←{1, skid}; pc_wen=0; next state FETCH. The next fetch address is already the advanced cpc.
- Latency: an instruction reaches the IF/ID outputs one edge after its ihit cycle; a skid-held instruction arrives one edge after stall deasserts.
- Throughput: one instruction per cycle while ihit=1 and stall=0.
- fetch_cnt wraps modulo 2^CNT_W.
- The PC never advances twice for one instruction, and a hit is never lost across a stall.

Test Plan:
- Reset then cpc=0x0, ihit=1, imemload=0x8C220004, no stall: imemREN=1 and imemaddr=0x0 in the first cycle; pc_wen=1; next edge gives ifid_valid=1, ifid_instr=0x8C220004, ifid_pc=0x0, ifid_pc_plus=0x4, fetch_cnt=1.
- ihit=0 for 3 cycles then ihit=1: pc_wen=0 and ifid_valid=0 for those 3 cycles; then exactly one pc_wen pulse and a valid instruction.
- Hit at cpc=0x10 with stall=1 for 2 cycles: pc_wen=1 only in the hit cycle, state HELD, imemREN=0, IF/ID unchanged. When stall drops, ifid_instr=skid value with ifid_pc=0x10, and fetch_cnt increments exactly once.
- flush coincident with ihit in FETCH, and separately flush while in HELD: pc_wen=1, ifid_valid=0 and ifid_instr=0 next edge, skid discarded, state FETCH, fetch_cnt unchanged.
- halt asserted with flush and ihit in the same cycle: state HALTED, imemREN=0, pc_wen=0, ifid_valid=0; these stay fixed for 10 cycles despite further ihit and flush pulses.
- Assert nRST low mid-HELD and asynchronously to CLK: all outputs reach reset values immediately; after release, fetch resumes from FETCH. Preload fetch_cnt to 0xFFFFFFFF, then one hit gives 0.
